// File: rtl/qbv_pkg.sv
// Shared types and default gate-schedule timing for the 802.1Qbv time-aware shaper.
// All times are in nanoseconds within one gate cycle.
package qbv_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SEND_BV,
      SEND_LEGACY
   } state_t;

   localparam int unsigned QBV_DATA_WIDTH    = 8;
   localparam logic [31:0] QBV_CYCLE_TIME_NS = 32'd20000;
   localparam logic [31:0] QBV_BV_OPEN_NS    = 32'd0;
   localparam logic [31:0] QBV_BV_CLOSE_NS   = 32'd8000;
   localparam logic [31:0] QBV_GUARD_BAND_NS = 32'd4000;

endpackage

// File: rtl/qbv_gate_timer.sv
// Gate timer: registers the PTP offset within the gate cycle (1 cycle latency) and
// derives the BV gate state and the legacy guard-band start permission; no flow control.
module qbv_gate_timer
   import qbv_pkg::*;
#(
   parameter logic [31:0] CYCLE_TIME_NS = QBV_CYCLE_TIME_NS,
   parameter logic [31:0] BV_OPEN_NS    = QBV_BV_OPEN_NS,
   parameter logic [31:0] BV_CLOSE_NS   = QBV_BV_CLOSE_NS,
   parameter logic [31:0] GUARD_BAND_NS = QBV_GUARD_BAND_NS
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [79:0] time_ptp_ns,
   output logic [31:0] offset_q,
   output logic        bv_open,
   output logic        legacy_start_ok
);

   logic [31:0] to_bv_raw;
   logic [31:0] to_bv;
   logic        unused_ptp_hi;

   // Only the nanosecond field matters; the seconds field rolls with it anyway.
   assign unused_ptp_hi = ^time_ptp_ns[79:32];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         offset_q <= '0;
      end else begin
         offset_q <= time_ptp_ns[31:0] % CYCLE_TIME_NS;
      end
   end

   // Offsets below the open point wrap to huge values, so one unsigned compare covers the window.
   always_comb begin
      bv_open         = (offset_q - BV_OPEN_NS) < (BV_CLOSE_NS - BV_OPEN_NS);
      to_bv_raw       = BV_OPEN_NS + CYCLE_TIME_NS - offset_q;
      to_bv           = (to_bv_raw >= CYCLE_TIME_NS) ? (to_bv_raw - CYCLE_TIME_NS) : to_bv_raw;
      legacy_start_ok = !bv_open && (to_bv >= GUARD_BAND_NS);
   end

endmodule

// File: rtl/qbv_time_aware_shaper.sv
// Qbv shaper: grants whole frames from the BV or legacy stream to the MAC, first beat 1 cycle
// after grant then zero-latency pass-through; MAC backpressure reaches the selected source same cycle.
module qbv_time_aware_shaper
   import qbv_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = QBV_DATA_WIDTH,
   parameter logic [31:0] CYCLE_TIME_NS = QBV_CYCLE_TIME_NS,
   parameter logic [31:0] BV_OPEN_NS    = QBV_BV_OPEN_NS,
   parameter logic [31:0] BV_CLOSE_NS   = QBV_BV_CLOSE_NS,
   parameter logic [31:0] GUARD_BAND_NS = QBV_GUARD_BAND_NS
) (
   input  logic                  tx_mac_aclk,
   input  logic                  tx_reset,
   input  logic [DATA_WIDTH-1:0] tx_axis_mac_legacy_tdata,
   input  logic                  tx_axis_mac_legacy_tvalid,
   output logic                  tx_axis_mac_legacy_tready,
   input  logic                  tx_axis_mac_legacy_tlast,
   input  logic [DATA_WIDTH-1:0] tx_axis_mac_bv_tdata,
   input  logic                  tx_axis_mac_bv_tvalid,
   output logic                  tx_axis_mac_bv_tready,
   input  logic                  tx_axis_mac_bv_tlast,
   input  logic [79:0]           time_ptp_ns,
   output logic [DATA_WIDTH-1:0] tx_axis_mac_tdata,
   output logic                  tx_axis_mac_tvalid,
   input  logic                  tx_axis_mac_tready,
   output logic                  tx_axis_mac_tlast,
   output logic                  tx_axis_mac_tuser
);

   state_t      state_q;
   state_t      state_d;
   logic        bv_open;
   logic        legacy_start_ok;
   logic [31:0] gate_offset_unused;

   qbv_gate_timer #(
      .CYCLE_TIME_NS (CYCLE_TIME_NS),
      .BV_OPEN_NS    (BV_OPEN_NS),
      .BV_CLOSE_NS   (BV_CLOSE_NS),
      .GUARD_BAND_NS (GUARD_BAND_NS)
   ) u_gate_timer (
      .clk             (tx_mac_aclk),
      .rst             (tx_reset),
      .time_ptp_ns     (time_ptp_ns),
      .offset_q        (gate_offset_unused),
      .bv_open         (bv_open),
      .legacy_start_ok (legacy_start_ok)
   );

   always_ff @(posedge tx_mac_aclk or posedge tx_reset) begin
      if (tx_reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Gates are only consulted in IDLE, so a frame already granted always runs to its tlast.
   always_comb begin
      state_d                   = state_q;
      tx_axis_mac_legacy_tready = 1'b0;
      tx_axis_mac_bv_tready     = 1'b0;
      tx_axis_mac_tvalid        = 1'b0;
      tx_axis_mac_tdata         = '0;
      tx_axis_mac_tlast         = 1'b0;
      case (state_q)
         IDLE: begin
            if (tx_axis_mac_bv_tvalid && bv_open) begin
               state_d = SEND_BV;
            end else if (tx_axis_mac_legacy_tvalid && legacy_start_ok) begin
               state_d = SEND_LEGACY;
            end
         end
         SEND_BV: begin
            tx_axis_mac_bv_tready = tx_axis_mac_tready;
            tx_axis_mac_tvalid    = tx_axis_mac_bv_tvalid;
            tx_axis_mac_tdata     = tx_axis_mac_bv_tvalid ? tx_axis_mac_bv_tdata : '0;
            tx_axis_mac_tlast     = tx_axis_mac_bv_tvalid && tx_axis_mac_bv_tlast;
            if (tx_axis_mac_bv_tvalid && tx_axis_mac_tready && tx_axis_mac_bv_tlast) begin
               state_d = IDLE;
            end
         end
         SEND_LEGACY: begin
            tx_axis_mac_legacy_tready = tx_axis_mac_tready;
            tx_axis_mac_tvalid        = tx_axis_mac_legacy_tvalid;
            tx_axis_mac_tdata         = tx_axis_mac_legacy_tvalid ? tx_axis_mac_legacy_tdata : '0;
            tx_axis_mac_tlast         = tx_axis_mac_legacy_tvalid && tx_axis_mac_legacy_tlast;
            if (tx_axis_mac_legacy_tvalid && tx_axis_mac_tready && tx_axis_mac_legacy_tlast) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign tx_axis_mac_tuser = 1'b0;

endmodule

// File: tb/tb_qbv_time_aware_shaper.sv
// Directed bench for qbv_time_aware_shaper: a table of single-beat grant decisions at fixed
// PTP offsets, then hand-written multi-cycle sequences with running PTP time (+40 ns per clock).
module tb_qbv_time_aware_shaper;

   typedef struct {
      logic [79:0] ptp;
      bit          leg;
      bit          bv;
      bit          e_leg_rdy;
      bit          e_bv_rdy;
      logic [7:0]  e_dat;
   } vec_t;

   logic        clk;
   logic        rst;
   logic [79:0] ptp;
   logic [7:0]  leg_dat;
   logic        leg_vld;
   logic        leg_rdy;
   logic        leg_last;
   logic [7:0]  bv_dat;
   logic        bv_vld;
   logic        bv_rdy;
   logic        bv_last;
   logic [7:0]  out_dat;
   logic        out_vld;
   logic        out_rdy;
   logic        out_last;
   logic        out_user;

   int          n_vec = 0;
   int          n_err = 0;

   logic [7:0]  leg_buf [0:63];
   logic [7:0]  bv_buf  [0:63];
   int          leg_len, leg_idx, bv_len, bv_idx;
   bit          leg_act, bv_act;
   bit          ptp_run, tog_mode;
   bit          leg_fire, bv_fire;
   bit          prev_tlast, prev_stall;
   logic [7:0]  prev_dat;
   int          smp;
   longint      leg_rdy_ptp, bv_rdy_ptp, bv_first_ptp, bv_last_ptp, leg_last_ptp;
   longint      leg_last_smp, bv_first_smp, after_leg_vld_smp, leg_first_dat;
   int          leg_beats, bv_beats, tlast_cnt;
   vec_t        tbl [16];

   qbv_time_aware_shaper dut (
      .tx_mac_aclk               (clk),
      .tx_reset                  (rst),
      .tx_axis_mac_legacy_tdata  (leg_dat),
      .tx_axis_mac_legacy_tvalid (leg_vld),
      .tx_axis_mac_legacy_tready (leg_rdy),
      .tx_axis_mac_legacy_tlast  (leg_last),
      .tx_axis_mac_bv_tdata      (bv_dat),
      .tx_axis_mac_bv_tvalid     (bv_vld),
      .tx_axis_mac_bv_tready     (bv_rdy),
      .tx_axis_mac_bv_tlast      (bv_last),
      .time_ptp_ns               (ptp),
      .tx_axis_mac_tdata         (out_dat),
      .tx_axis_mac_tvalid        (out_vld),
      .tx_axis_mac_tready        (out_rdy),
      .tx_axis_mac_tlast         (out_last),
      .tx_axis_mac_tuser         (out_user)
   );

   initial begin
      clk = 1'b0;
      forever #20 clk = ~clk;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   task automatic drive();
      leg_vld  = leg_act && (leg_idx < leg_len);
      leg_dat  = leg_vld ? leg_buf[leg_idx] : 8'h00;
      leg_last = leg_vld && (leg_idx == leg_len - 1);
      bv_vld   = bv_act && (bv_idx < bv_len);
      bv_dat   = bv_vld ? bv_buf[bv_idx] : 8'h00;
      bv_last  = bv_vld && (bv_idx == bv_len - 1);
   endtask

   task automatic sample();
      bit lf, bf, of;
      smp++;
      lf = leg_vld && leg_rdy;
      bf = bv_vld && bv_rdy;
      of = out_vld && out_rdy;
      if (prev_tlast) chk("idle_gap", out_vld, 0);
      if (prev_stall && !rst) begin
         chk("hold_vld", out_vld, 1);
         chk("hold_dat", out_dat, prev_dat);
      end
      if (out_vld) chk("one_rdy", leg_rdy && bv_rdy, 0);
      if (of) begin
         chk("beat_src", lf ^ bf, 1);
         if (lf) begin
            chk("leg_dat", out_dat, leg_buf[leg_idx]);
            chk("leg_last", out_last, leg_idx == leg_len - 1);
         end else if (bf) begin
            chk("bv_dat", out_dat, bv_buf[bv_idx]);
            chk("bv_last", out_last, bv_idx == bv_len - 1);
         end
         chk("tuser", out_user, 0);
         if (out_last) tlast_cnt++;
      end
      if (leg_rdy && leg_rdy_ptp < 0) leg_rdy_ptp = longint'(ptp[31:0]);
      if (bv_rdy && bv_rdy_ptp < 0) bv_rdy_ptp = longint'(ptp[31:0]);
      if (lf) begin
         leg_beats++;
         if (leg_first_dat < 0) leg_first_dat = longint'(out_dat);
         if (leg_idx == leg_len - 1) begin
            leg_last_smp = smp;
            leg_last_ptp = longint'(ptp[31:0]);
         end
      end
      if (bf) begin
         bv_beats++;
         if (bv_first_smp < 0) begin
            bv_first_smp = smp;
            bv_first_ptp = longint'(ptp[31:0]);
         end
         if (bv_idx == bv_len - 1) bv_last_ptp = longint'(ptp[31:0]);
      end
      if (leg_act && leg_idx == leg_len && out_vld && after_leg_vld_smp < 0) after_leg_vld_smp = smp;
      prev_tlast = of && out_last;
      prev_stall = out_vld && !out_rdy;
      prev_dat   = out_dat;
      leg_fire   = lf;
      bv_fire    = bf;
   endtask

   // One clock: check outputs at the falling edge, then advance sources/time just after the rise.
   task automatic step();
      @(negedge clk);
      sample();
      @(posedge clk);
      #1;
      if (leg_fire) leg_idx++;
      if (bv_fire) bv_idx++;
      if (ptp_run) ptp = ptp + 80'd40;
      out_rdy = tog_mode ? ~out_rdy : 1'b1;
      drive();
   endtask

   task automatic clear_trk();
      leg_rdy_ptp = -1; bv_rdy_ptp = -1; bv_first_ptp = -1; bv_last_ptp = -1;
      leg_last_ptp = -1; leg_last_smp = -1; bv_first_smp = -1; after_leg_vld_smp = -1;
      leg_first_dat = -1; leg_beats = 0; bv_beats = 0; tlast_cnt = 0;
   endtask

   task automatic seq_begin(input int llen, input int blen);
      clear_trk();
      leg_act = 0; bv_act = 0; leg_idx = 0; bv_idx = 0;
      leg_len = llen; bv_len = blen;
      leg_buf[0] = 8'h01; leg_buf[1] = 8'h80; leg_buf[2] = 8'hC2;
      for (int i = 3; i < 64; i++) leg_buf[i] = 8'hFF - 8'(60 - i);
      for (int i = 0; i < 64; i++) bv_buf[i] = 8'h10 + 8'(i);
      drive();
   endtask

   task automatic set_ptp(input logic [79:0] v);
      ptp = v;
      step();
      step();
   endtask

   task automatic wait_done(input int budget, input string name);
      int  n;
      bit  done;
      n = 0;
      done = 0;
      while (!done && n < budget) begin
         step();
         n++;
         done = (!leg_act || leg_idx >= leg_len) && (!bv_act || bv_idx >= bv_len);
      end
      chk(name, done, 1);
      step();
      step();
      leg_act = 0;
      bv_act = 0;
      drive();
   endtask

   initial begin
      tbl[0]  = '{80'd0,          1, 1, 0, 1, 8'h5A};
      tbl[1]  = '{80'd0,          1, 0, 0, 0, 8'h00};
      tbl[2]  = '{80'd7999,       0, 1, 0, 1, 8'h5A};
      tbl[3]  = '{80'd7999,       1, 0, 0, 0, 8'h00};
      tbl[4]  = '{80'd8000,       0, 1, 0, 0, 8'h00};
      tbl[5]  = '{80'd8000,       1, 0, 1, 0, 8'hA5};
      tbl[6]  = '{80'd8000,       1, 1, 1, 0, 8'hA5};
      tbl[7]  = '{80'd16000,      1, 0, 1, 0, 8'hA5};
      tbl[8]  = '{80'd16001,      1, 0, 0, 0, 8'h00};
      tbl[9]  = '{80'd16040,      1, 0, 0, 0, 8'h00};
      tbl[10] = '{80'd19999,      0, 1, 0, 0, 8'h00};
      tbl[11] = '{80'd20000,      0, 1, 0, 1, 8'h5A};
      tbl[12] = '{80'd28000,      1, 0, 1, 0, 8'hA5};
      tbl[13] = '{80'hFFFF_FFFF,  1, 0, 0, 0, 8'h00};
      tbl[14] = '{80'hFFFF_FFFF,  0, 1, 0, 1, 8'h5A};
      tbl[15] = '{{48'h1234_5678_9ABC, 32'd12000}, 1, 0, 1, 0, 8'hA5};

      rst = 1'b1; ptp = '0; out_rdy = 1'b1; ptp_run = 0; tog_mode = 0;
      smp = 0; prev_tlast = 0; prev_stall = 0; prev_dat = '0; leg_fire = 0; bv_fire = 0;
      seq_begin(1, 1);
      leg_act = 1; bv_act = 1;
      drive();
      #5;
      chk("rst_leg_rdy", leg_rdy, 0);
      chk("rst_bv_rdy", bv_rdy, 0);
      chk("rst_vld", out_vld, 0);
      chk("rst_last", out_last, 0);
      chk("rst_dat", out_dat, 0);
      chk("rst_user", out_user, 0);
      leg_act = 0; bv_act = 0;
      drive();
      @(posedge clk);
      #1;
      step();
      rst = 1'b0;

      // Single-beat grant decisions with the PTP clock frozen at each offset.
      for (int i = 0; i < 16; i++) begin
         seq_begin(1, 1);
         leg_buf[0] = 8'hA5;
         bv_buf[0]  = 8'h5A;
         ptp = tbl[i].ptp;
         step();
         step();
         leg_act = tbl[i].leg;
         bv_act  = tbl[i].bv;
         drive();
         step();
         chk($sformatf("v%0d_leg_rdy", i), leg_rdy, tbl[i].e_leg_rdy);
         chk($sformatf("v%0d_bv_rdy", i), bv_rdy, tbl[i].e_bv_rdy);
         chk($sformatf("v%0d_vld", i), out_vld, tbl[i].e_leg_rdy | tbl[i].e_bv_rdy);
         chk($sformatf("v%0d_last", i), out_last, tbl[i].e_leg_rdy | tbl[i].e_bv_rdy);
         chk($sformatf("v%0d_dat", i), out_dat, tbl[i].e_dat);
         repeat (3) step();
         leg_act = 0; bv_act = 0;
         drive();
         step();
      end

      ptp_run = 1;

      // Legacy frame offered inside the BV window waits for the gate to close.
      seq_begin(61, 1);
      set_ptp(80'd1200);
      leg_act = 1; drive();
      wait_done(400, "A_done");
      chk("A_rdy_ptp", leg_rdy_ptp, 8080);
      chk("A_beats", leg_beats, 61);
      chk("A_tlasts", tlast_cnt, 1);

      // BV frame offered in the legacy window waits for the wrap to offset 0.
      seq_begin(1, 61);
      set_ptp(80'd11000);
      bv_act = 1; drive();
      wait_done(400, "B_done");
      chk("B_rdy_ptp", bv_rdy_ptp, 20080);
      chk("B_first_ptp", bv_first_ptp, 20080);
      chk("B_last_ptp", bv_last_ptp, 22480);
      chk("B_beats", bv_beats, 61);

      // Both pending across the wrap: BV wins, legacy waits for the gate to close.
      seq_begin(10, 10);
      set_ptp(80'd39000);
      leg_act = 1; bv_act = 1; drive();
      wait_done(400, "C_done");
      chk("C_bv_rdy_ptp", bv_rdy_ptp, 40080);
      chk("C_leg_rdy_ptp", leg_rdy_ptp, 48080);
      chk("C_tlasts", tlast_cnt, 2);

      // Inside the guard band: legacy is deferred to the next cycle.
      seq_begin(5, 1);
      set_ptp(80'd56000);
      leg_act = 1; drive();
      wait_done(500, "D_done");
      chk("D_rdy_ptp", leg_rdy_ptp, 68080);

      // Legacy started just before the guard band with a stuttering MAC; BV queued behind it.
      seq_begin(61, 8);
      tog_mode = 1;
      set_ptp(80'd15920);
      leg_act = 1; bv_act = 1; drive();
      wait_done(400, "E_done");
      tog_mode = 0;
      chk("E_leg_beats", leg_beats, 61);
      chk("E_bv_beats", bv_beats, 8);
      chk("E_leg_crossed_wrap", leg_last_ptp >= 20000, 1);
      chk("E_bv_after_leg", bv_first_smp > leg_last_smp, 1);
      chk("E_bv_grant_smp", after_leg_vld_smp, leg_last_smp + 2);

      // Reset mid-frame, then the frame is re-offered from its first byte.
      seq_begin(20, 1);
      set_ptp(80'd8000);
      leg_act = 1; drive();
      for (int n = 0; n < 50 && leg_idx < 5; n++) step();
      chk("F_started", leg_idx, 5);
      rst = 1'b1;
      #1;
      chk("F_rst_leg_rdy", leg_rdy, 0);
      chk("F_rst_bv_rdy", bv_rdy, 0);
      chk("F_rst_vld", out_vld, 0);
      chk("F_rst_last", out_last, 0);
      chk("F_rst_dat", out_dat, 0);
      chk("F_rst_user", out_user, 0);
      leg_idx = 0;
      prev_stall = 0;
      prev_tlast = 0;
      drive();
      step();
      step();
      rst = 1'b0;
      clear_trk();
      wait_done(100, "F_done");
      chk("F_first_dat", leg_first_dat, 1);
      chk("F_beats", leg_beats, 20);
      chk("F_tlasts", tlast_cnt, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
